// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: FETCH/EXEC handshake with instruction memory
// and next-PC selection. Define PERF_CNT_EN to add commit/taken performance counters.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic             instr_valid,
    input  logic [1:0]       jump_ctrl,
    input  logic             branch_eq,
    input  logic             branch_neq,
    input  logic             alu_zero,
    input  logic [31:0]      rs_data,
    input  logic             stall,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] perf_instr_cnt,
    output logic [CNT_W-1:0] perf_taken_cnt,
`endif
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4
);

    typedef enum logic [0:0] {StFetch, StExec} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic [31:0] next_pc;
    logic [31:0] br_offset;
    logic        taken;

    // Register targets are word-aligned by dropping the low two bits.
    logic unused_rs_low;
    assign unused_rs_low = ^rs_data[1:0];

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign taken     = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);

    always_comb begin
        next_pc = pc_plus4;
        unique case (jump_ctrl)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            2'b10: next_pc = {rs_data[31:2], 2'b00};
            2'b11: next_pc = taken ? (pc_plus4 + br_offset) : pc_plus4;
            default: next_pc = pc_plus4;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] perf_instr_q;
    logic [CNT_W-1:0] perf_taken_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
`ifdef PERF_CNT_EN
            perf_instr_q  <= '0;
            perf_taken_q  <= '0;
`endif
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        state_q       <= StExec;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                StExec: begin
                    if (!stall) begin
                        pc_q          <= next_pc;
                        state_q       <= StFetch;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
`ifdef PERF_CNT_EN
                        perf_instr_q  <= perf_instr_q + CNT_W'(1);
                        if (next_pc != pc_plus4) begin
                            perf_taken_q <= perf_taken_q + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q       <= StFetch;
                    imem_req_q    <= 1'b1;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = instr_valid_q;

`ifdef PERF_CNT_EN
    assign perf_instr_cnt = perf_instr_q;
    assign perf_taken_cnt = perf_taken_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit; counter checks are built when PERF_CNT_EN is defined.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [1:0]  jump_ctrl;
    logic        branch_eq;
    logic        branch_neq;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef PERF_CNT_EN
    logic [31:0] perf_instr_cnt;
    logic [31:0] perf_taken_cnt;
`endif

    int vectors;
    int miscompares;

    localparam logic [31:0] AddWord = 32'h0022_1820;
    localparam logic [31:0] JrWord  = 32'h0020_0008;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .opcode         (opcode),
        .funct          (funct),
        .instr_valid    (instr_valid),
        .jump_ctrl      (jump_ctrl),
        .branch_eq      (branch_eq),
        .branch_neq     (branch_neq),
        .alu_zero       (alu_zero),
        .rs_data        (rs_data),
        .stall          (stall),
`ifdef PERF_CNT_EN
        .perf_instr_cnt (perf_instr_cnt),
        .perf_taken_cnt (perf_taken_cnt),
`endif
        .pc             (pc),
        .pc_plus4       (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus drivers: all inputs change at the falling edge, outputs are read there too.
    task automatic do_fetch(input logic [31:0] word, input int waits);
        imem_ready = 1'b0;
        for (int i = 0; i < waits; i++) @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_exec(input logic [1:0] ctrl, input logic beq, input logic bne,
                           input logic zero, input logic [31:0] rs);
        jump_ctrl  = ctrl;
        branch_eq  = beq;
        branch_neq = bne;
        alu_zero   = zero;
        rs_data    = rs;
        stall      = 1'b0;
        @(negedge clk);
        jump_ctrl  = 2'b00;
        branch_eq  = 1'b0;
        branch_neq = 1'b0;
        alu_zero   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: pc=%h req=%b addr=%h valid=%b, want 0/1/0/0",
                     pc, imem_req, imem_addr, instr_valid);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (instr !== 32'h0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: instr=%h pc=%h valid=%b, want 0/0/0", instr, pc, instr_valid);
        end
        imem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b, want 1/0/0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_seq_fetch();
        do_fetch(AddWord, 0);
        vectors++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== AddWord ||
            opcode !== 6'h00 || funct !== 6'h20 || pc_plus4 !== 32'h4) begin
            miscompares++;
            $display("FAIL seq_exec0: valid=%b req=%b instr=%h op=%h fn=%h p4=%h, want 1/0/%h/00/20/4",
                     instr_valid, imem_req, instr, opcode, funct, pc_plus4, AddWord);
        end
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== AddWord) begin
            miscompares++;
            $display("FAIL seq_addr4: addr=%h req=%b valid=%b instr=%h, want 4/1/0/%h",
                     imem_addr, imem_req, instr_valid, instr, AddWord);
        end
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_wait%0d: addr=%h req=%b valid=%b, want 4/1/0",
                         i, imem_addr, imem_req, instr_valid);
            end
        end
        do_fetch(32'h0043_2022, 0);
        vectors++;
        if (instr !== 32'h0043_2022 || funct !== 6'h22 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_late_instr: instr=%h fn=%h valid=%b, want 00432022/22/1",
                     instr, funct, instr_valid);
        end
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL seq_addr8: addr=%h, want 00000008", imem_addr);
        end
    endtask

    task automatic test_jump();
        do_fetch(JrWord, 1);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h1000_0040);
        vectors++;
        if (pc !== 32'h1000_0040) begin
            miscompares++;
            $display("FAIL jump_setup_pc: pc=%h, want 10000040", pc);
        end
        do_fetch(32'h0800_0010, 0);
        vectors++;
        if (opcode !== 6'h02) begin
            miscompares++;
            $display("FAIL jump_opcode: op=%h, want 02", opcode);
        end
        do_exec(2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h1000_0040) begin
            miscompares++;
            $display("FAIL jump_target: addr=%h, want 10000040", imem_addr);
        end
    endtask

    task automatic test_branch();
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
        do_fetch(32'h1000_FFFF, 0);
        do_exec(2'b11, 1'b1, 1'b0, 1'b1, 32'h0);
        vectors++;
        if (imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL beq_taken: addr=%h, want 00000100", imem_addr);
        end
        do_fetch(32'h1000_FFFF, 0);
        do_exec(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL beq_not_taken: addr=%h, want 00000104", imem_addr);
        end
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
        do_fetch(32'h1400_FFFF, 0);
        do_exec(2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL bne_taken: addr=%h, want 00000100", imem_addr);
        end
        // Forward branch, both flags raised: always taken. 0x104 + 0x20 = 0x124.
        do_fetch(32'h1000_0008, 0);
        do_exec(2'b11, 1'b1, 1'b1, 1'b1, 32'h0);
        vectors++;
        if (imem_addr !== 32'h124) begin
            miscompares++;
            $display("FAIL branch_both_flags: addr=%h, want 00000124", imem_addr);
        end
    endtask

    task automatic test_jr_wrap();
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_2003);
        vectors++;
        if (imem_addr !== 32'h2000) begin
            miscompares++;
            $display("FAIL jr_align: addr=%h, want 00002000", imem_addr);
        end
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        do_fetch(AddWord, 0);
        vectors++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_plus4: pc=%h p4=%h, want fffffffc/00000000", pc, pc_plus4);
        end
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_seq: addr=%h, want 00000000", imem_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc_at;
        pc_at = pc;
        do_fetch(32'h0085_3024, 0);
        stall      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (pc !== pc_at || instr !== 32'h0085_3024 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d: pc=%h instr=%h valid=%b req=%b, want %h/00853024/1/0",
                         i, pc, instr, instr_valid, imem_req, pc_at);
            end
        end
        imem_ready = 1'b0;
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (imem_addr !== pc_at + 32'd4 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: addr=%h valid=%b, want %h/0", imem_addr, instr_valid,
                     pc_at + 32'd4);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0300);
        imem_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (pc !== 32'h0 || imem_req !== 1'b1 || instr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_fetch: pc=%h req=%b instr=%h, want 0/1/0", pc, imem_req, instr);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_after: valid=%b addr=%h instr=%h, want 0/0/0",
                     instr_valid, imem_addr, instr);
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        vectors++;
        if (perf_instr_cnt !== 32'h0 || perf_taken_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL perf_reset: instr_cnt=%0d taken_cnt=%0d, want 0/0",
                     perf_instr_cnt, perf_taken_cnt);
        end
        do_fetch(AddWord, 0);
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(AddWord, 0);
        do_exec(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        do_fetch(JrWord, 0);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
        do_fetch(32'h1000_FFFF, 1);
        stall = 1'b1;
        @(negedge clk);
        do_exec(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        vectors++;
        if (perf_instr_cnt !== 32'd4 || perf_taken_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL perf_counts: instr_cnt=%0d taken_cnt=%0d, want 4/1",
                     perf_instr_cnt, perf_taken_cnt);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        jump_ctrl   = 2'b00;
        branch_eq   = 1'b0;
        branch_neq  = 1'b0;
        alu_zero    = 1'b0;
        rs_data     = 32'h0;
        stall       = 1'b0;
        @(negedge clk);
        test_reset();
        test_seq_fetch();
        test_jump();
        test_branch();
        test_jr_wrap();
        test_stall();
        test_reset_mid_fetch();
`ifdef PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
